// File: rtl/nibble_serial_add_ctrl.sv
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Serial adder sequencer. A single 4-bit carry-lookahead slice
//               is reused over WIDTH/4 clocks, least significant nibble first,
//               with a carry register chaining the slices. A valid/ready
//               command port starts an operation and a valid/ready result
//               port hands the sum and carry-out to the consumer.
//               Optional build macro NIBBLE_ADD_SUB_EN adds a 'sub' input
//               that turns the operation into a - b (co=1 means no borrow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             do_sub;

  logic [3:0]       nib_a, nib_b, p, g, slice_sum;
  logic [4:0]       c;

`ifdef NIBBLE_ADD_SUB_EN
  assign do_sub = sub;
`else
  assign do_sub = 1'b0;
`endif

  assign accept = (state == IDLE) && start_valid;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One 4-bit lookahead slice on the current nibble, carries fully expanded.
  always_comb begin
    nib_a = op_a[{idx, 2'b00} +: 4];
    nib_b = op_b[{idx, 2'b00} +: 4];
    p     = nib_a ^ nib_b;
    g     = nib_a & nib_b;
    c[0]  = carry;
    c[1]  = g[0] | (p[0] & carry);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & carry);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry);
    slice_sum = p ^ c[3:0];
  end

  // Datapath: latch operands on accept, then fold in one nibble per RUN cycle.
  // Subtraction is a + ~b + 1, so the inversion and forced carry happen here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= do_sub ? ~b : b;
      carry <= do_sub ? 1'b1 : ci;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[{idx, 2'b00} +: 4] <= slice_sum;
      carry <= c[4];
      idx   <= idx + 1'b1;
      if (idx == LAST_IDX) co <= c[4];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
//               Expected results come from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a, b;
  logic             ci;
  logic             sub;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .ci          (ci),
`ifdef NIBBLE_ADD_SUB_EN
    .sub         (sub),
`endif
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .co          (co),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the block is ready for a command.
  task automatic wait_ready();
    int k;
    k = 0;
    while (start_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("wait_start_ready", {31'd0, start_ready}, 32'd1);
  endtask

  // Full operation: accept, check RUN length, hold result for 'hold' cycles
  // with disturbing inputs, then release it and check the return to IDLE.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tc, input logic tsub, input int hold);
    logic [WIDTH:0]   ref_full;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_co;
    if (tsub) begin
      exp_sum = WIDTH'((int'(ta) - int'(tb_v)) & ((1 << WIDTH) - 1));
      exp_co  = (ta >= tb_v);
    end else begin
      ref_full = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tc};
      exp_sum  = ref_full[WIDTH-1:0];
      exp_co   = ref_full[WIDTH];
    end
    wait_ready();
    a = ta; b = tb_v; ci = tc; sub = tsub; start_valid = 1'b1; done_ready = 1'b0;
    step();                          // accept edge T
    start_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    for (int k = 0; k < NIB; k++) begin
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_start_ready", {31'd0, start_ready}, 32'd0);
      chk("run_done_valid", {31'd0, done_valid}, 32'd0);
      step();
    end
    chk("done_valid", {31'd0, done_valid}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("sum", {16'd0, sum}, {16'd0, exp_sum});
    chk("co", {31'd0, co}, {31'd0, exp_co});
    for (int k = 0; k < hold; k++) begin
      start_valid = ~start_valid;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      step();
      chk("hold_sum", {16'd0, sum}, {16'd0, exp_sum});
      chk("hold_co", {31'd0, co}, {31'd0, exp_co});
      chk("hold_done_valid", {31'd0, done_valid}, 32'd1);
      chk("hold_start_ready", {31'd0, start_ready}, 32'd0);
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    step();                          // edge T+N+1 (plus hold)
    done_ready  = 1'b0;
    chk("release_start_ready", {31'd0, start_ready}, 32'd1);
    chk("release_done_valid", {31'd0, done_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    done_ready = 1'b0;
    #12;
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
    #10 rst = 1'b0;
    step();
    chk("idle_start_ready", {31'd0, start_ready}, 32'd1);
    chk("idle_done_valid", {31'd0, done_valid}, 32'd0);
    chk("idle_sum", {16'd0, sum}, 32'd0);
    chk("idle_co", {31'd0, co}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Directed cases.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
    do_op(16'h00F0, 16'h0F10, 1'b0, 1'b0, 5);

    // Reset mid-operation after two RUN cycles.
    wait_ready();
    a = 16'h8888; b = 16'h8888; ci = 1'b0; sub = 1'b0; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_co", {31'd0, co}, 32'd0);
    chk("abort_done_valid", {31'd0, done_valid}, 32'd0);
    chk("abort_start_ready", {31'd0, start_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    #10 rst = 1'b0;
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0);

`ifdef NIBBLE_ADD_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1);
`endif

    // Randomized operations.
    for (int i = 0; i < 25; i++) begin
`ifdef NIBBLE_ADD_SUB_EN
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
`else
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0,
            int'($urandom_range(0, 3)));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by driving one internal 4-bit carry-lookahead slice over successive nibbles, one nibble per clock, least significant nibble first.
- A carry register chains the slices.
- Sits between a requester (valid/ready command port) and a consumer (valid/ready result port).
- Trades latency for area versus a full-width lookahead adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start_valid  input  1  requester has a command
start_ready  output  1  block can accept a command
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
ci  input  1  carry-in to the least significant nibble, sampled on accept
done_valid  output  1  result available
done_ready  input  1  consumer takes the result
sum  output  WIDTH  result
co  output  1  carry out of the most significant nibble
busy  output  1  high in RUN

Behaviour:
- Reset is asynchronous and active-high. Outputs while rst is high and after it deasserts:
  - state=IDLE
  - start_ready=1
  - done_valid=0
  - busy=0
  - sum=0
  - co=0
  - internal operand, carry and nibble-index registers = 0
- Reset asserted at any point aborts any operation in flight. No partial result is ever presented.
- Define N = WIDTH/4. The nibble index is clog2(N) bits wide, minimum 1.
- Slice equations per nibble:
  - p=a^b, g=a&b
  - c[0]=carry register
  - c[i+1]=g[i] | (p[i] & c[i]), fully expanded lookahead form
  - sum nibble = p ^ c[3:0]
  - slice carry out = c[4]
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: latch a, b and ci (into the carry register), clear the index, go to RUN.
- RUN:
  - start_ready=0, busy=1.
  - Each edge: write the slice sum into sum[4*idx+3:4*idx], load the carry register with the slice carry out, increment idx.
  - On the edge that processes idx=N-1: load co with that slice's carry out and go to DONE.
  - RUN lasts exactly N cycles.
- DONE:
  - done_valid=1; sum and co stay stable while done_valid=1 and done_ready=0.
  - start_ready=0, so there is no overlap between operations.
  - On an edge with done_ready=1: go to IDLE, done_valid=0.
- Latency: for an accept at edge T, done_valid rises after edge T+N. The next command can be accepted at edge T+N+2 at the earliest, with done_ready held high.
- sum bits not yet written during RUN hold their previous values. They are only meaningful when done_valid=1.
- Inputs a, b and ci may change freely after accept; they do not affect the operation in flight.
- start_valid held high in RUN or DONE is ignored. The command is taken only once IDLE is re-entered.
- done_ready while not in DONE is ignored.
- WIDTH=4: RUN lasts 1 cycle.

Optional Feature:
- Macro: NIBBLE_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on accept.
  - When sub=1, the latched B is ~b and the initial carry is 1 (ci is ignored), giving result = a - b mod 2^WIDTH.
  - co=1 means no borrow (a >= b, unsigned).
  - When sub=0, behaviour is identical to the undefined case.
- Not defined: port sub does not exist; the block is add-only.

Test Plan:
- WIDTH=16, reset, then check idle outputs -> start_ready=1, done_valid=0, sum=0x0000, co=0, busy=0.
- a=0x1234, b=0x4321, ci=0, accepted at edge T, done_ready=1 -> busy for 4 cycles, done_valid rises after edge T+4, sum=0x5555, co=0; start_ready=1 again after edge T+5.
- a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1; also a=0xFFFF, b=0x0000, ci=1 -> sum=0x0000, co=1 (carry ripples through all 4 nibbles).
- a=0x00F0, b=0x0F10, ci=0, done_ready held 0 for 5 cycles while a, b and start_valid toggle -> sum=0x1000, co=0 held stable, start_ready=0 throughout; one cycle after done_ready=1, start_ready=1.
- Accept a=0x8888, b=0x8888, then assert rst after 2 RUN cycles -> immediately sum=0, co=0, done_valid=0, start_ready=1. A subsequent a=0x0001, b=0x0002 -> sum=0x0003, co=0.
- With NIBBLE_ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, co=0; sub=1, a=0x0007, b=0x0005 -> sum=0x0002, co=1.
